// File: rtl/matrix_pkg.sv
// Shared types and default geometry for the matrix producer/consumer path.
package matrix_pkg;

    localparam int unsigned MAT_WIDTH = 10;
    localparam int unsigned MAT_DEPTH = 10;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    typedef logic [MAT_WIDTH-1:0] row_t;
    typedef row_t [MAT_DEPTH-1:0] mat_t;

endpackage

// File: rtl/matrix_row_serializer_popcount.sv
// Combinational ones counter for one matrix row; shared with the consumer side.
module popcount #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            o_count = o_count + CNT_W'(i_data[i]);
        end
    end

endmodule

// File: rtl/matrix_row_serializer.sv
// Accepts a whole matrix in one transfer and streams it out one row per beat,
// reloading on the last-row handshake so consecutive matrices have no bubble.
module matrix_row_serializer
    import matrix_pkg::*;
#(
    parameter int unsigned WIDTH = MAT_WIDTH,
    parameter int unsigned DEPTH = MAT_DEPTH,
    parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_mat_valid,
    output logic                         o_mat_ready,
    input  logic [DEPTH-1:0][WIDTH-1:0]  i_mat,
    output logic                         o_row_valid,
    input  logic                         i_row_ready,
    output logic [WIDTH-1:0]             o_row,
    output logic [IDX_W-1:0]             o_row_idx,
    output logic                         o_row_last,
    output logic [CNT_W-1:0]             o_row_ones,
    output logic                         o_busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [DEPTH-1:0][WIDTH-1:0]  mat_q, mat_d;

    logic                         at_last;

    assign at_last = (idx_q == LAST_IDX);

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mat_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mat_q   <= mat_d;
        end
    end

    // Next state: a last-row handshake with a pending matrix reloads in place
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mat_d   = mat_q;
        case (state_q)
            IDLE: begin
                if (i_mat_valid) begin
                    mat_d   = i_mat;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (i_row_ready) begin
                    if (at_last) begin
                        idx_d = '0;
                        if (i_mat_valid) begin
                            mat_d = i_mat;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs; row fields are forced to zero outside SEND
    always_comb begin
        o_row_valid = 1'b0;
        o_row       = '0;
        o_row_idx   = '0;
        o_row_last  = 1'b0;
        o_busy      = 1'b0;
        o_mat_ready = 1'b1;
        if (state_q == SEND) begin
            o_row_valid = 1'b1;
            o_row       = mat_q[idx_q];
            o_row_idx   = idx_q;
            o_row_last  = at_last;
            o_busy      = 1'b1;
            o_mat_ready = i_row_ready & at_last;
        end
    end

    popcount #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_popcount (
        .i_data  (o_row),
        .o_count (o_row_ones)
    );

endmodule

// File: tb/tb_matrix_row_serializer.sv
// Directed bench for matrix_row_serializer: streaming, stalls, back-to-back, reset.
module tb_matrix_row_serializer;
    import matrix_pkg::*;

    localparam int unsigned W  = MAT_WIDTH;
    localparam int unsigned D  = MAT_DEPTH;
    localparam int unsigned IW = 4;
    localparam int unsigned CW = 4;

    logic           clk;
    logic           rst_n;
    logic           mat_valid;
    logic           mat_ready;
    mat_t           mat;
    logic           row_valid;
    logic           row_ready;
    logic [W-1:0]   row;
    logic [IW-1:0]  row_idx;
    logic           row_last;
    logic [CW-1:0]  row_ones;
    logic           busy;

    int total = 0;
    int bad   = 0;

    mat_t ramp;
    int   ramp_ones [10] = '{0, 1, 1, 2, 1, 2, 2, 3, 1, 2};

    matrix_row_serializer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_mat_valid (mat_valid),
        .o_mat_ready (mat_ready),
        .i_mat       (mat),
        .o_row_valid (row_valid),
        .i_row_ready (row_ready),
        .o_row       (row),
        .o_row_idx   (row_idx),
        .o_row_last  (row_last),
        .o_row_ones  (row_ones),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; mat_valid = 1'b0; row_ready = 1'b0; mat = '0;
        #2;
        total++; if (row_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", row_valid); end
        total++; if (row !== '0) begin bad++; $display("FAIL reset_row got=%h want=0", row); end
        total++; if (row_idx !== '0) begin bad++; $display("FAIL reset_idx got=%0d want=0", row_idx); end
        total++; if (row_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", row_last); end
        total++; if (row_ones !== '0) begin bad++; $display("FAIL reset_ones got=%0d want=0", row_ones); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (mat_ready !== 1'b1) begin bad++; $display("FAIL reset_mat_ready got=%b want=1", mat_ready); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Offer a matrix one cycle ahead of the accepting edge, leave valid low after
    task automatic accept(input mat_t m);
        @(posedge clk); #1;
        mat = m; mat_valid = 1'b1;
        #1;
        total++; if (mat_ready !== 1'b1 || row_valid !== 1'b0) begin
            bad++; $display("FAIL accept_idle got ready=%b valid=%b want ready=1 valid=0", mat_ready, row_valid);
        end
        @(posedge clk); #1;
        mat_valid = 1'b0; mat = '0;
    endtask

    task automatic test_stream();
        row_ready = 1'b1;
        accept(ramp);
        #1;
        for (int k = 0; k < 10; k++) begin
            total++; if (row_valid !== 1'b1) begin bad++; $display("FAIL stream_valid k=%0d got=%b want=1", k, row_valid); end
            total++; if (row_idx !== IW'(k)) begin bad++; $display("FAIL stream_idx got=%0d want=%0d", row_idx, k); end
            total++; if (row !== W'(k)) begin bad++; $display("FAIL stream_row k=%0d got=%h want=%h", k, row, W'(k)); end
            total++; if (row_ones !== CW'(ramp_ones[k])) begin bad++; $display("FAIL stream_ones k=%0d got=%0d want=%0d", k, row_ones, ramp_ones[k]); end
            total++; if (row_last !== (k == 9)) begin bad++; $display("FAIL stream_last k=%0d got=%b want=%b", k, row_last, k == 9); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL stream_busy k=%0d got=%b want=1", k, busy); end
            total++; if (mat_ready !== (k == 9)) begin bad++; $display("FAIL stream_mat_ready k=%0d got=%b want=%b", k, mat_ready, k == 9); end
            @(posedge clk); #2;
        end
        total++; if (row_valid !== 1'b0 || busy !== 1'b0 || mat_ready !== 1'b1) begin
            bad++; $display("FAIL stream_idle got valid=%b busy=%b ready=%b want 0 0 1", row_valid, busy, mat_ready);
        end
    endtask

    task automatic test_stall();
        int exp_idx;
        exp_idx = 0;
        row_ready = 1'b1;
        accept(ramp);
        for (int j = 0; j < 19; j++) begin
            row_ready = (j % 2 == 0);
            #1;
            total++; if (row_valid !== 1'b1 || row_idx !== IW'(exp_idx) || row !== W'(exp_idx)) begin
                bad++; $display("FAIL stall_row j=%0d got valid=%b idx=%0d row=%h want idx=%0d", j, row_valid, row_idx, row, exp_idx);
            end
            total++; if (row_last !== (exp_idx == 9)) begin bad++; $display("FAIL stall_last j=%0d got=%b want=%b", j, row_last, exp_idx == 9); end
            if (row_ready) exp_idx++;
            @(posedge clk); #1;
        end
        row_ready = 1'b1;
        #1;
        total++; if (row_valid !== 1'b0 || exp_idx != 10) begin
            bad++; $display("FAIL stall_done got valid=%b beats=%0d want valid=0 beats=10", row_valid, exp_idx);
        end
    endtask

    task automatic test_back_to_back();
        mat_t ones_m;
        ones_m = '1;
        row_ready = 1'b1;
        @(posedge clk); #1;
        mat = ones_m; mat_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) begin
            mat = '0;
            mat_valid = (k < 10);
            #1;
            total++; if (row_valid !== 1'b1 || row_idx !== IW'(k % 10)) begin
                bad++; $display("FAIL b2b_beat k=%0d got valid=%b idx=%0d want 1 %0d", k, row_valid, row_idx, k % 10);
            end
            total++; if (row_ones !== ((k < 10) ? CW'(10) : CW'(0))) begin
                bad++; $display("FAIL b2b_ones k=%0d got=%0d want=%0d", k, row_ones, (k < 10) ? 10 : 0);
            end
            total++; if (row !== ((k < 10) ? {W{1'b1}} : {W{1'b0}})) begin
                bad++; $display("FAIL b2b_row k=%0d got=%h", k, row);
            end
            total++; if (mat_ready !== (k % 10 == 9)) begin
                bad++; $display("FAIL b2b_mat_ready k=%0d got=%b want=%b", k, mat_ready, k % 10 == 9);
            end
            @(posedge clk); #1;
        end
        mat_valid = 1'b0;
        #1;
        total++; if (row_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", row_valid); end
    endtask

    task automatic test_hold_input();
        row_ready = 1'b1;
        accept(ramp);
        for (int k = 0; k < 10; k++) begin
            mat_valid = (k < 9);
            for (int r = 0; r < int'(D); r++) mat[r] = W'($urandom);
            #1;
            total++; if (mat_ready !== (k == 9)) begin bad++; $display("FAIL hold_mat_ready k=%0d got=%b want=%b", k, mat_ready, k == 9); end
            total++; if (row !== ramp[k] || row_idx !== IW'(k)) begin
                bad++; $display("FAIL hold_row k=%0d got row=%h idx=%0d want row=%h", k, row, row_idx, ramp[k]);
            end
            @(posedge clk); #1;
        end
        mat_valid = 1'b0; mat = '0;
        #1;
        total++; if (row_valid !== 1'b0 || mat_ready !== 1'b1) begin
            bad++; $display("FAIL hold_idle got valid=%b ready=%b want 0 1", row_valid, mat_ready);
        end
    endtask

    task automatic test_mid_reset();
        row_ready = 1'b1;
        accept(ramp);
        repeat (4) @(posedge clk);
        #1;
        total++; if (row_idx !== IW'(4) || row !== W'(4)) begin
            bad++; $display("FAIL mreset_pre got idx=%0d row=%h want 4", row_idx, row);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (row_valid !== 1'b0 || busy !== 1'b0 || row_last !== 1'b0) begin
            bad++; $display("FAIL mreset_ctrl got valid=%b busy=%b last=%b want 0", row_valid, busy, row_last);
        end
        total++; if (row !== '0 || row_idx !== '0 || row_ones !== '0) begin
            bad++; $display("FAIL mreset_data got row=%h idx=%0d ones=%0d want 0", row, row_idx, row_ones);
        end
        total++; if (mat_ready !== 1'b1) begin bad++; $display("FAIL mreset_ready got=%b want=1", mat_ready); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++; if (row_valid !== 1'b0 || mat_ready !== 1'b1 || row !== '0 || busy !== 1'b0) begin
                bad++; $display("FAIL mreset_after c=%0d got valid=%b ready=%b row=%h busy=%b", c, row_valid, mat_ready, row, busy);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < int'(D); r++) ramp[r] = W'(r);
        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_hold_input();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
